// File: rtl/core_pkg.sv
// Types and constants shared between the fetch unit and its prefetch buffer.
package core_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries; flush beats push and pop.
// When empty, the head output keeps showing the last entry that was at the head.
module fetch_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push_i,
   input  logic [$bits(fetch_entry_t)-1:0]  entry_i,
   input  logic                             pop_i,
   input  logic                             flush_i,
   output logic [CW-1:0]                    count_o,
   output logic [$bits(fetch_entry_t)-1:0]  head_o
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   fetch_entry_t  hold_q, hold_d;
   fetch_entry_t  head;
   logic          do_pop;

   always_comb begin
      do_pop   = pop_i & (cnt_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      head     = (cnt_q != '0) ? mem_q[rd_ptr_q] : hold_q;
      hold_d   = head;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = fetch_entry_t'(entry_i);
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         hold_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
      end
   end

   assign count_o = cnt_q;
   assign head_o  = head;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a credit-limited prefetch buffer between a
// request/grant instruction memory and decode; redirects flush and squash stale responses.
module ifu_prefetch
   import core_pkg::*;
#(
   parameter int              XLEN     = core_pkg::XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = core_pkg::DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   live_q, live_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic            run_q, run_d;
   logic [CW-1:0]   fifo_cnt;
   logic [CW:0]     credit_sum;
   logic            grant;
   logic            keep;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] redirect_pc;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;
   logic [$bits(fetch_entry_t)-1:0] head_bits;
   logic            unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc_i[1:0];
   assign redirect_pc    = {redirect_pc_i[XLEN-1:2], 2'b00};

   // Stale (dropped) requests do not hold buffer space, so only live ones count against credit.
   assign credit_sum    = {1'b0, fifo_cnt} + {1'b0, live_q};
   assign imem_req_o    = run_q & (credit_sum < (CW+1)'(DEPTH));
   assign imem_addr_o   = fetch_pc_q;
   assign grant         = imem_req_o & imem_gnt_i;
   assign keep          = imem_rvalid_i & (drop_q == '0);
   assign push          = keep & ~redirect_i;
   assign instr_valid_o = (fifo_cnt != '0);
   assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;

   always_comb begin
      push_entry       = '0;
      push_entry.pc    = resp_pc_q;
      push_entry.instr = imem_rdata_i;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      live_d     = live_q;
      drop_d     = drop_q;
      run_d      = 1'b1;
      if (redirect_i) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         live_d     = '0;
         // Everything granted so far, including this cycle, is now unwanted.
         drop_d     = drop_q + live_q + CW'(grant) - CW'(imem_rvalid_i);
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
         end
         live_d = live_q + CW'(grant) - CW'(keep);
         drop_d = drop_q - CW'(imem_rvalid_i & ~keep);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         live_q     <= '0;
         drop_q     <= '0;
         run_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         live_q     <= live_d;
         drop_q     <= drop_d;
         run_q      <= run_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .entry_i (push_entry),
      .pop_i   (pop),
      .flush_i (redirect_i),
      .count_o (fifo_cnt),
      .head_o  (head_bits)
   );

   assign head_entry = fetch_entry_t'(head_bits);
   assign instr_o    = head_entry.instr;
   assign instr_pc_o = head_entry.pc;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an in-order memory model that returns the address as data.
module tb_ifu_prefetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;

   int checks = 0;
   int errors = 0;

   // memory model state
   logic [31:0] q_addr[$];
   int          q_due[$];
   int          cyc_n = 0;
   int          lat = 1;
   logic        gnt_en = 1'b1;
   int          ngrant = 0;

   typedef struct {
      logic        ready;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t vecs[9];

   ifu_prefetch #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; then play the memory for the new cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      if (q_due.size() > 0 && q_due[0] <= cyc_n) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = q_addr[0];
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
      imem_gnt_i = gnt_en;
      if (imem_req_o && gnt_en) begin
         q_addr.push_back(imem_addr_o);
         q_due.push_back(cyc_n + lat);
         ngrant++;
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      redirect_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      q_addr.delete();
      q_due.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      ngrant = 0;
   endtask

   logic [31:0] pops[3];
   int          npop;
   int          old_seen;

   initial begin
      rst_n         = 1'b0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      instr_ready_i = 1'b1;

      //             ready req  addr          valid pc
      vecs[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      vecs[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      vecs[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      vecs[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      vecs[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      vecs[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
      vecs[6] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
      vecs[7] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
      vecs[8] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", imem_req_o, 0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_valid", instr_valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", instr_pc_o, 0);
      rst_n = 1'b1;

      // streaming with 1-cycle memory, one stall cycle
      lat = 1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk($sformatf("vec%0d_req", i), imem_req_o, vecs[i].exp_req);
         chk($sformatf("vec%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
         chk($sformatf("vec%0d_valid", i), instr_valid_o, vecs[i].exp_valid);
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d_pc", i), instr_pc_o, vecs[i].exp_pc);
            chk($sformatf("vec%0d_instr", i), instr_o, vecs[i].exp_pc);
         end
         instr_ready_i = vecs[i].ready;
      end

      // decode stalled: credit stops at DEPTH grants, then drains in order
      instr_ready_i = 1'b0;
      do_reset();
      repeat (8) cyc();
      chk("stall_grants", ngrant, 4);
      chk("stall_req", imem_req_o, 0);
      chk("stall_valid", instr_valid_o, 1);
      instr_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("drain%0d_pc", i), instr_pc_o, 32'(4 * i));
         chk($sformatf("drain%0d_instr", i), instr_o, 32'(4 * i));
         if (i == 1) begin
            chk("resume_req", imem_req_o, 1);
            chk("resume_addr", imem_addr_o, 32'h10);
         end
         cyc();
      end

      // redirect with three requests outstanding on 3-cycle memory
      do_reset();
      lat = 3;
      repeat (3) cyc();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h100;
      cyc();
      redirect_i = 1'b0;
      chk("redir_req", imem_req_o, 1);
      chk("redir_addr", imem_addr_o, 32'h100);
      chk("redir_valid", instr_valid_o, 0);
      npop     = 0;
      old_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (instr_valid_o) begin
            if (instr_pc_o < 32'h100 || instr_o < 32'h100) old_seen++;
            if (npop < 3) begin
               pops[npop] = instr_pc_o;
               npop++;
            end
         end
         cyc();
      end
      chk("redir_old_seen", old_seen, 0);
      chk("redir_npop", npop, 3);
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("redir_pop%0d", j), pops[j], 32'h100 + 32'(4 * j));
      end

      // redirect coinciding with grant, response and pop; unaligned target
      do_reset();
      lat = 1;
      repeat (4) cyc();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h203;
      cyc();
      redirect_i = 1'b0;
      chk("same_valid1", instr_valid_o, 0);
      chk("same_addr1", imem_addr_o, 32'h200);
      chk("same_req1", imem_req_o, 1);
      cyc();
      chk("same_valid2", instr_valid_o, 0);
      cyc();
      chk("same_valid3", instr_valid_o, 1);
      chk("same_pc3", instr_pc_o, 32'h200);
      chk("same_instr3", instr_o, 32'h200);

      // address wrap at the top of the address space
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      cyc();
      redirect_i = 1'b0;
      chk("wrap_addr1", imem_addr_o, 32'hFFFF_FFFC);
      cyc();
      chk("wrap_addr2", imem_addr_o, 32'h0000_0000);
      cyc();
      chk("wrap_pc1", instr_pc_o, 32'hFFFF_FFFC);
      chk("wrap_instr1", instr_o, 32'hFFFF_FFFC);
      cyc();
      chk("wrap_pc2", instr_pc_o, 32'h0);
      repeat (2) cyc();
      chk("wrap_pc4", instr_pc_o, 32'h8);

      // asynchronous reset mid-stream
      #2;
      rst_n         = 1'b0;
      imem_rvalid_i = 1'b0;
      q_addr.delete();
      q_due.delete();
      #1;
      chk("arst_req", imem_req_o, 0);
      chk("arst_addr", imem_addr_o, 32'h0);
      chk("arst_valid", instr_valid_o, 0);
      chk("arst_instr", instr_o, 0);
      chk("arst_pc", instr_pc_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();
      chk("restart_req", imem_req_o, 1);
      chk("restart_addr", imem_addr_o, 32'h0);
      cyc();
      chk("restart_addr2", imem_addr_o, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
